// File: rtl/trigger_tx_if.sv
// Trigger TX request/status and DI2C bus bundle.
// master: requester side; slave: trigger_tx side.
interface trigger_tx_if;
  logic        trig_req;
  logic [7:0]  sub_system_id;
  logic [7:0]  trigger_type;
  logic        serial_clear;
  logic        busy_in;
  logic        scl;
  logic        sda;
  logic        tx_active;
  logic        trig_done;
  logic        trig_rejected;
  logic [31:0] trigger_serial;

  modport master (
    output trig_req, sub_system_id,
    output trigger_type, serial_clear,
    output busy_in,
    input  scl, sda, tx_active,
    input  trig_done, trig_rejected,
    input  trigger_serial
  );

  modport slave (
    input  trig_req, sub_system_id,
    input  trigger_type, serial_clear,
    input  busy_in,
    output scl, sda, tx_active,
    output trig_done, trig_rejected,
    output trigger_serial
  );
endinterface

// File: rtl/trigger_tx.sv
// DI2C trigger package transmitter: 6 payload bytes + KERMIT CRC.
// Ports: clk, reset (sync, high), bus (trigger_tx_if.slave).
// Option: TRIGGER_TX_BUSY_CHECK_EN rejects requests while busy.
module trigger_tx #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  trigger_tx_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, CALC, START, BIT_LOW,
    BIT_HIGH, STOP_LOW, STOP_HIGH, GAP
  } state_t;

  localparam logic [9:0] LP_LAST = 10'(CLK_DIV - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_tmr;
  logic [3:0]  r_bit_cnt;
  logic [2:0]  r_byte_cnt;
  logic [63:0] r_frame;
  logic [15:0] r_crc;
  logic [31:0] r_serial;
  logic        r_done;
  logic        r_rej;
  logic [1:0]  r_busy_sync;

  logic        w_busy_blk;
  logic        w_accept;
  logic        w_tmr_last;
  logic        w_calc_last;
  logic        w_frame_last;
  logic        w_bit;
  logic        w_scl;
  logic        w_sda;
  logic [31:0] w_ser_eff;
  logic [5:0]  w_crc_idx;
  logic        w_crc_fb;
  logic [15:0] w_crc_nxt;

  always_ff @(posedge clk) begin
    if (reset) r_busy_sync <= 2'b00;
    else       r_busy_sync <= {r_busy_sync[0], bus.busy_in};
  end

`ifdef TRIGGER_TX_BUSY_CHECK_EN
  assign w_busy_blk = r_busy_sync[1];
`else
  logic w_unused_busy;
  assign w_unused_busy = ^r_busy_sync;
  assign w_busy_blk    = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) &&
                    bus.trig_req && !w_busy_blk;
  // A coinciding clear wins: the package carries 0.
  assign w_ser_eff = bus.serial_clear ? 32'h0 : r_serial;

  assign w_tmr_last   = (r_tmr == LP_LAST);
  assign w_calc_last  = (r_tmr == 10'd47);
  assign w_frame_last = (r_bit_cnt == 4'd8) &&
                        (r_byte_cnt == 3'd7);
  // Ninth slot of every byte is a released (high) line.
  assign w_bit = (r_bit_cnt == 4'd8) ? 1'b1 : r_frame[63];

  // Payload bits LSB-first within each byte, bytes in order.
  assign w_crc_idx = 6'(7'd56
                   - {1'b0, r_tmr[5:3], 3'b000}
                   + {4'b0000, r_tmr[2:0]});
  assign w_crc_fb  = r_crc[0] ^ r_frame[w_crc_idx];
  assign w_crc_nxt = {1'b0, r_crc[15:1]} ^
                     (w_crc_fb ? 16'h8408 : 16'h0000);

  always_comb begin
    w_state_nxt = r_state;
    w_scl       = 1'b1;
    w_sda       = 1'b1;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = CALC;
      end
      CALC: begin
        if (w_calc_last) w_state_nxt = START;
      end
      START: begin
        w_sda = 1'b0;
        if (w_tmr_last) w_state_nxt = BIT_LOW;
      end
      BIT_LOW: begin
        w_scl = 1'b0;
        w_sda = w_bit;
        if (w_tmr_last) w_state_nxt = BIT_HIGH;
      end
      BIT_HIGH: begin
        w_sda = w_bit;
        if (w_tmr_last)
          w_state_nxt = w_frame_last ? STOP_LOW : BIT_LOW;
      end
      STOP_LOW: begin
        w_scl = 1'b0;
        w_sda = 1'b0;
        if (w_tmr_last) w_state_nxt = STOP_HIGH;
      end
      STOP_HIGH: begin
        w_sda = 1'b0;
        if (w_tmr_last) w_state_nxt = GAP;
      end
      GAP: begin
        if (w_tmr_last) w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_tmr      <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_frame    <= '0;
      r_crc      <= '0;
      r_serial   <= '0;
      r_done     <= 1'b0;
      r_rej      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= (w_state_nxt != r_state) ? 10'd0
                                          : r_tmr + 10'd1;
      r_done  <= 1'b0;
      r_rej   <= bus.trig_req && !w_accept;
      if (r_state == IDLE) begin
        if (bus.serial_clear) r_serial <= '0;
        if (w_accept) begin
          r_frame <= {bus.sub_system_id,
                      bus.trigger_type,
                      w_ser_eff, 16'h0000};
          r_crc      <= '0;
          r_bit_cnt  <= '0;
          r_byte_cnt <= '0;
        end
      end
      if (r_state == CALC) begin
        r_crc <= w_crc_nxt;
        if (w_calc_last) r_frame[15:0] <= w_crc_nxt;
      end
      if (r_state == BIT_HIGH && w_tmr_last) begin
        if (r_bit_cnt == 4'd8) begin
          r_bit_cnt  <= '0;
          r_byte_cnt <= r_byte_cnt + 3'd1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
          r_frame   <= {r_frame[62:0], 1'b0};
        end
      end
      if (r_state == GAP && w_tmr_last) begin
        r_done   <= 1'b1;
        r_serial <= r_serial + 32'd1;
      end
    end
  end

  assign bus.scl            = w_scl;
  assign bus.sda            = w_sda;
  assign bus.tx_active      = (r_state != IDLE);
  assign bus.trig_done      = r_done;
  assign bus.trig_rejected  = r_rej;
  assign bus.trigger_serial = r_serial;

endmodule

// File: doc/trigger_tx.md
TRIGGER_TX -- requirements
Module: trigger_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 10, the SCL half-period in clk cycles (legal range 2..1023).
REQ-002 SHALL have port clk  input  1  system clock, 10-100 MHz.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port trig_req  input  1  single-cycle request to send one trigger package.
REQ-005 SHALL have port sub_system_id  input  8  target sub-system ID, sampled on request acceptance.
REQ-006 SHALL have port trigger_type  input  8  trigger type, sampled on request acceptance.
REQ-007 SHALL have port serial_clear  input  1  zeroes the internal serial counter.
REQ-008 SHALL have port busy_in  input  1  OR of the sub-system busy lines, asynchronous.
REQ-009 SHALL have port scl  output  1  DI2C clock to the SCL transceiver DI.
REQ-010 SHALL have port sda  output  1  DI2C data to the SDA transceiver DI.
REQ-011 SHALL have port tx_active  output  1  high from request acceptance until trig_done.
REQ-012 SHALL have port trig_done  output  1  one-cycle pulse when the package is completely sent.
REQ-013 SHALL have port trig_rejected  output  1  one-cycle pulse when a request is dropped.
REQ-014 SHALL have port trigger_serial  output  32  serial number of the current or next package.

Function
REQ-015 SHALL drive the frame as 8 bytes, MSB first: sub_system_id, trigger_type, serial[31:24], [23:16], [15:8], [7:0], crc[15:8], crc[7:0].
REQ-016 SHALL compute crc as CRC-16/KERMIT over the 6 payload bytes: reflected poly 0x8408, init 0x0000, refin/refout, no xorout.
REQ-017 SHALL use FSM states IDLE, CALC, START, BIT_LOW, BIT_HIGH, STOP_LOW, STOP_HIGH, GAP.
REQ-018 SHALL, in IDLE, hold scl=1 and sda=1, and accept trig_req by latching the inputs and trigger_serial, then enter CALC.
REQ-019 SHALL, in CALC, shift the 48 payload bits LSB-first per byte into a serial CRC register, one bit per clk (48 cycles), then enter START.
REQ-020 SHALL, in START, drive sda=0 with scl=1 for CLK_DIV cycles, then drive scl=0 and enter BIT_LOW.
REQ-021 SHALL, on entering BIT_LOW, update sda to the next bit, hold scl=0 for CLK_DIV cycles, then hold scl=1 in BIT_HIGH for CLK_DIV cycles.
REQ-022 SHALL send 9 SCL pulses per byte (8 data bits plus a 9th slot with sda=1), 72 pulses in total.
REQ-023 SHALL, after the 72nd pulse, go to STOP_LOW (scl=0, sda=0, CLK_DIV cycles), then STOP_HIGH (scl=1, sda=0, CLK_DIV cycles), then raise sda.
REQ-024 SHALL hold the idle bus for CLK_DIV cycles in GAP, then pulse trig_done, increment the serial, and return to IDLE.
REQ-025 SHALL never change sda while scl=1, except in the START and STOP edges.
REQ-026 SHALL fix the latency from trig_req to trig_done at 48 + 148*CLK_DIV + 1 cycles.
REQ-027 SHALL increment the serial modulo 2^32, so 0xFFFFFFFF wraps to 0x00000000.
REQ-028 SHALL reject trig_req when not in IDLE (pulse trig_rejected the next cycle, frame unaffected).
REQ-029 SHALL act on serial_clear only in IDLE; when serial_clear and trig_req coincide, the clear wins and the package carries serial 0.
REQ-030 SHALL synchronise busy_in through two flip-flops before use.

Reset
REQ-031 SHALL, on reset, force: state IDLE, scl=1, sda=1, tx_active=0, trig_done=0, trig_rejected=0, trigger_serial=0, and the CRC register to 0.
REQ-032 SHALL abort any frame when reset is asserted mid-frame, release the bus idle in the next cycle, and emit no trig_done.

Configuration
REQ-033 SHALL, with macro TRIGGER_TX_BUSY_CHECK_EN defined, reject trig_req in IDLE while synchronised busy_in=1 (trig_rejected pulse, no frame, serial unchanged).
REQ-034 SHALL, without TRIGGER_TX_BUSY_CHECK_EN, ignore busy_in entirely, except for its synchroniser, which may be optimised away.

Verification
REQ-035 SHALL cover: CLK_DIV=4, id=0x00, type=0x00, serial=0 -> 72 SCL pulses, all data bits 0, crc bytes 0x00 0x00, trig_done at cycle 48+592+1, then trigger_serial=1.
REQ-036 SHALL cover: id=0xA5, type=0x3C, serial preset to 0xFFFFFFFE by 2 frames after preloading -> byte stream decoded by the bench matches, crc equals the software KERMIT model, and serial wraps to 0x00000000 after 0xFFFFFFFF.
REQ-037 SHALL cover: trig_req during frame byte 3 -> trig_rejected pulse, frame bit-identical to a frame with no second request.
REQ-038 SHALL cover: busy_in=1 and trig_req with TRIGGER_TX_BUSY_CHECK_EN -> trig_rejected, no bus activity; the same stimulus without the macro -> full frame sent.
REQ-039 SHALL cover: reset asserted at SCL pulse 40 -> scl=1, sda=1 on the next cycle, no trig_done, and the next request sends serial 0.
REQ-040 SHALL cover: a loopback into the DI2C receiver block with serial 0x12345678 -> receiver reports identical fields, CRC status OK, and busy asserted.
